// File: rtl/cellrv32_onewire_device.sv
// 1-Wire bus device (slave): reset/presence handling and LSB-first read-while-write bit slots.
// Optional glitch filter on the line input: define CELLRV32_ONEWIRE_DEV_GLITCH_FILTER_EN.
module cellrv32_onewire_device #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FE00,
    parameter int          T_SAMPLE    = 4,
    parameter int          T_DRIVE0    = 6,
    parameter int          T_RESET_MIN = 32,
    parameter int          T_PDH       = 2,
    parameter int          T_PDL       = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] addr_i,
    input  logic        rden_i,
    input  logic        wren_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        clkgen_en_o,
    input  logic [7:0]  clkgen_i,
    input  logic        onewire_i,
    output logic        onewire_o,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        S_OFFLINE, S_IDLE, S_SLOT, S_WAIT_HIGH, S_RST_LOW, S_PDH, S_PDL
    } state_t;

    localparam logic [6:0] TS   = 7'(T_SAMPLE);
    localparam logic [6:0] TD   = 7'(T_DRIVE0);
    localparam logic [6:0] TR   = 7'(T_RESET_MIN);
    localparam logic [6:0] TPDH = 7'(T_PDH);
    localparam logic [6:0] TPDL = 7'(T_PDL);

    state_t      state_q;
    logic        en_q, overrun_q, reset_seen_q, rx_ready_q, tx_valid_q, tx_fresh_q;
    logic [1:0]  prsc_q;
    logic [7:0]  div_q, div_cnt_q;
    logic [6:0]  tick_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  tx_buf_q, tx_sreg_q, rx_sreg_q, rx_byte_q;
    logic        ow_q, irq_q, ack_q;
    logic [31:0] data_q;
    logic [1:0]  sync_q;
    logic        line_s, line_prev_q;

    // ---------------- bus decode ----------------
    logic match, wr_ctrl, wr_data, rd_ctrl, rd_data, en_d;
    assign match   = (addr_i[31:3] == BASE_ADDR[31:3]);
    assign wr_ctrl = wren_i & match & ~addr_i[2];
    assign wr_data = wren_i & match &  addr_i[2];
    assign rd_ctrl = rden_i & match & ~addr_i[2];
    assign rd_data = rden_i & match &  addr_i[2];
    // A disabling CTRL write takes the line back in the same cycle it lands.
    assign en_d    = wr_ctrl ? data_i[0] : en_q;

    logic unused_ok;
    assign unused_ok = ^{clkgen_i[7:4], addr_i[1:0], data_i[26:11], data_i[31:29]};

    // ---------------- tick generation ----------------
    logic tap, tick;
    assign tap  = clkgen_i[prsc_q];
    assign tick = en_q & tap & (div_cnt_q == div_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)    div_cnt_q <= '0;
        else if (!en_q) div_cnt_q <= '0;
        else if (tap)   div_cnt_q <= (div_cnt_q == div_q) ? 8'd0 : div_cnt_q + 8'd1;
    end

    // ---------------- input path ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q      <= 2'b11;
            line_prev_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[0], onewire_i};
            line_prev_q <= line_s;
        end
    end

`ifdef CELLRV32_ONEWIRE_DEV_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
            filt_q <= line_s;
        end
    end
    // Follow the synchronized input only once it has held for three cycles.
    assign line_s = ((sync_q[1] == hist_q[0]) && (sync_q[1] == hist_q[1])) ? sync_q[1] : filt_q;
`else
    assign line_s = sync_q[1];
`endif

    logic fall;
    assign fall = line_prev_q & ~line_s;

    // ---------------- slot helpers ----------------
    logic [6:0] tick_nx, cnt_adv;
    logic [7:0] tx_load;
    logic       tx_first, smp_ev, byte_done, rst_enter, busy;
    assign tick_nx   = (tick_cnt_q == 7'd127) ? 7'd127 : tick_cnt_q + 7'd1;
    assign cnt_adv   = tick ? tick_nx : tick_cnt_q;
    assign tx_load   = tx_valid_q ? tx_buf_q : 8'hFF;
    assign tx_first  = (bit_cnt_q == 3'd0) ? tx_load[0] : tx_sreg_q[0];
    assign smp_ev    = (state_q == S_SLOT) & tick & (tick_nx == TS);
    assign byte_done = smp_ev & (bit_cnt_q == 3'd7);
    assign rst_enter = en_d & (cnt_adv >= TR) &
                       ((state_q == S_SLOT) | ((state_q == S_WAIT_HIGH) & ~line_s));
    assign busy      = (state_q != S_IDLE) & (state_q != S_OFFLINE);

    // ---------------- control + FSM ----------------
    // Later assignments override earlier ones: line events beat W1C / read-clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_OFFLINE;
            en_q         <= 1'b0;
            prsc_q       <= '0;
            div_q        <= '0;
            overrun_q    <= 1'b0;
            reset_seen_q <= 1'b0;
            rx_ready_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_fresh_q   <= 1'b0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            tx_buf_q     <= '0;
            tx_sreg_q    <= 8'hFF;
            rx_sreg_q    <= '0;
            rx_byte_q    <= '0;
            ow_q         <= 1'b1;
            irq_q        <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (rd_data) rx_ready_q <= 1'b0;
            if (wr_ctrl) begin
                en_q   <= data_i[0];
                prsc_q <= data_i[2:1];
                div_q  <= data_i[10:3];
                if (data_i[27]) overrun_q    <= 1'b0;
                if (data_i[28]) reset_seen_q <= 1'b0;
            end
            if (wr_data) begin
                tx_buf_q   <= data_i[7:0];
                tx_valid_q <= 1'b1;
                // Written mid-byte: must survive this byte's completion.
                if (bit_cnt_q != 3'd0) tx_fresh_q <= 1'b1;
            end

            if (!en_d) begin
                state_q      <= S_OFFLINE;
                ow_q         <= 1'b1;
                rx_ready_q   <= 1'b0;
                overrun_q    <= 1'b0;
                reset_seen_q <= 1'b0;
                bit_cnt_q    <= '0;
                tx_valid_q   <= 1'b0;
                tx_fresh_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_OFFLINE: begin
                        ow_q    <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    S_IDLE: if (fall) begin
                        tick_cnt_q <= '0;
                        state_q    <= S_SLOT;
                        ow_q       <= tx_first;
                        if (bit_cnt_q == 3'd0) tx_sreg_q <= tx_load;
                    end
                    S_SLOT: begin
                        tick_cnt_q <= cnt_adv;
                        if (smp_ev) begin
                            rx_sreg_q <= {line_s, rx_sreg_q[7:1]};
                            tx_sreg_q <= {1'b1, tx_sreg_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                        if (byte_done) begin
                            rx_byte_q  <= {line_s, rx_sreg_q[7:1]};
                            if (rx_ready_q) overrun_q <= 1'b1;
                            rx_ready_q <= 1'b1;
                            tx_valid_q <= tx_fresh_q | wr_data;
                            tx_fresh_q <= 1'b0;
                            irq_q      <= 1'b1;
                        end
                        if (tick && tick_nx == TD) begin
                            ow_q    <= 1'b1;
                            state_q <= S_WAIT_HIGH;
                        end
                    end
                    S_WAIT_HIGH: begin
                        tick_cnt_q <= cnt_adv;
                        if (line_s) state_q <= S_IDLE;
                    end
                    S_RST_LOW: if (line_s) begin
                        tick_cnt_q <= '0;
                        state_q    <= S_PDH;
                    end
                    S_PDH: begin
                        tick_cnt_q <= cnt_adv;
                        if (tick && tick_nx == TPDH) begin
                            ow_q       <= 1'b0;
                            tick_cnt_q <= '0;
                            state_q    <= S_PDL;
                        end
                    end
                    S_PDL: begin
                        tick_cnt_q <= cnt_adv;
                        if (tick && tick_nx == TPDL) begin
                            ow_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_OFFLINE;
                endcase
                if (rst_enter) begin
                    state_q      <= S_RST_LOW;
                    ow_q         <= 1'b1;
                    bit_cnt_q    <= '0;
                    rx_sreg_q    <= '0;
                    reset_seen_q <= 1'b1;
                    irq_q        <= 1'b1;
                end
            end
        end
    end

    // ---------------- bus response ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q  <= (rden_i | wren_i) & match;
            data_q <= '0;
            if (rd_ctrl)
                data_q <= {busy, rx_ready_q, line_s, reset_seen_q, overrun_q,
                           16'd0, div_q, prsc_q, en_q};
            else if (rd_data)
                data_q <= {24'd0, rx_byte_q};
        end
    end

    assign data_o      = data_q;
    assign ack_o       = ack_q;
    assign clkgen_en_o = en_q;
    assign onewire_o   = ow_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_cellrv32_onewire_device.sv
// Directed bench for cellrv32_onewire_device: a host model drives the line as a wired-AND.
module tb_cellrv32_onewire_device;

    localparam logic [31:0] A_CTRL = 32'hFFFF_FE00;
    localparam logic [31:0] A_DATA = 32'hFFFF_FE04;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        rden_i = 1'b0;
    logic        wren_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        ack_o;
    logic        clkgen_en_o;
    logic [7:0]  clkgen_i = 8'hFF;
    logic        onewire_i;
    logic        onewire_o;
    logic        irq_o;
    logic        host_drv = 1'b1;

    cellrv32_onewire_device dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .addr_i(addr_i), .rden_i(rden_i), .wren_i(wren_i),
        .data_i(data_i), .data_o(data_o), .ack_o(ack_o), .clkgen_en_o(clkgen_en_o),
        .clkgen_i(clkgen_i), .onewire_i(onewire_i), .onewire_o(onewire_o), .irq_o(irq_o)
    );

    assign onewire_i = host_drv & onewire_o;
    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    int irq_cnt = 0;

    always @(negedge clk_i) if (irq_o === 1'b1) irq_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        addr_i = a; data_i = d; wren_i = 1'b1;
        @(negedge clk_i);
        wren_i = 1'b0;
        chk("wr_ack", {31'd0, ack_o}, 32'd1);
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk_i);
        addr_i = a; rden_i = 1'b1;
        @(negedge clk_i);
        rden_i = 1'b0;
        d = data_o;
        chk("rd_ack", {31'd0, ack_o}, 32'd1);
    endtask

    // One host slot starting at a negedge: write-1 low 10 cycles, write-0 low 70, read at 20.
    task automatic host_slot(input logic wbit, output logic rbit);
        rbit = 1'b1;
        for (int c = 0; c < 90; c++) begin
            if (c == 0) host_drv = 1'b0;
            if (c == 10 && wbit) host_drv = 1'b1;
            if (c == 70) host_drv = 1'b1;
            if (c == 20) rbit = onewire_i;
            @(negedge clk_i);
        end
    endtask

    task automatic host_byte(input logic [7:0] wb, output logic [7:0] rb);
        logic b;
        for (int i = 0; i < 8; i++) begin
            host_slot(wb[i], b);
            rb[i] = b;
        end
    endtask

    task automatic host_reset(output int dly, output int len);
        host_drv = 1'b0;
        repeat (480) @(negedge clk_i);
        host_drv = 1'b1;
        dly = 0;
        while (onewire_o !== 1'b0 && dly < 100) begin @(negedge clk_i); dly++; end
        len = 0;
        while (onewire_o === 1'b0 && len < 400) begin @(negedge clk_i); len++; end
        repeat (10) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  rb;
        logic        b;
        int          dly, len, irq0;

        // Reset values
        repeat (3) @(negedge clk_i);
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_ow", {31'd0, onewire_o}, 32'd1);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("rst_clkgen", {31'd0, clkgen_en_o}, 32'd0);
        rstn_i = 1'b1;
        bus_rd(A_CTRL, rd);
        chk("rst_ctrl", rd, 32'h2000_0000);

        // Unmapped address: no ack, no data
        @(negedge clk_i);
        addr_i = 32'hFFFF_FE08; rden_i = 1'b1;
        @(negedge clk_i);
        rden_i = 1'b0;
        chk("unmapped_ack", {31'd0, ack_o}, 32'd0);
        chk("unmapped_data", data_o, 32'd0);

        // Enable, prsc=0, clk_div=9
        bus_wr(A_CTRL, 32'h0000_0049);
        chk("clkgen_en", {31'd0, clkgen_en_o}, 32'd1);
        repeat (5) @(negedge clk_i);

        // Reset and presence
        irq0 = irq_cnt;
        host_reset(dly, len);
        chk("pres_dly_ok", {31'd0, (dly >= 12 && dly <= 25)}, 32'd1);
        chk("pres_len", len, 32'd160);
        chk("rst_irq_cnt", irq_cnt - irq0, 32'd1);
        bus_rd(A_CTRL, rd);
        chk("ctrl_rst_seen", rd, 32'h3000_0049);
        bus_wr(A_CTRL, 32'h1000_0049);
        bus_rd(A_CTRL, rd);
        chk("ctrl_w1c_rst", rd, 32'h2000_0049);

        // Receive 0xA5: irq exactly at 8th sample
        irq0 = irq_cnt;
        for (int i = 0; i < 7; i++) host_slot(1'((8'hA5 >> i) & 8'h01), b);
        chk("rx_irq_7", irq_cnt - irq0, 32'd0);
        host_slot(1'b1, b);
        chk("rx_irq_8", irq_cnt - irq0, 32'd1);
        bus_rd(A_CTRL, rd);
        chk("rx_ready", rd, 32'h6000_0049);
        bus_rd(A_DATA, rd);
        chk("rx_A5", rd, 32'h0000_00A5);
        bus_rd(A_CTRL, rd);
        chk("rx_ready_clr", rd, 32'h2000_0049);

        // Transmit 0x3C with host write-1 slots
        bus_wr(A_DATA, 32'h0000_003C);
        host_byte(8'hFF, rb);
        chk("tx_host_3C", {24'd0, rb}, 32'h0000_003C);
        bus_rd(A_DATA, rd);
        chk("tx_rx_3C", rd, 32'h0000_003C);

        // tx_valid cleared: next byte is idle 0xFF
        host_byte(8'hFF, rb);
        chk("tx_idle_FF", {24'd0, rb}, 32'h0000_00FF);
        bus_rd(A_DATA, rd);
        chk("rx_FF", rd, 32'h0000_00FF);

        // Reset mid-byte with a byte already pending, then overrun
        host_byte(8'h5A, rb);
        bus_rd(A_CTRL, rd);
        chk("pend_5A", rd, 32'h6000_0049);
        host_slot(1'b1, b);
        host_slot(1'b1, b);
        host_slot(1'b0, b);
        irq0 = irq_cnt;
        host_reset(dly, len);
        chk("mid_pres_dly_ok", {31'd0, (dly >= 12 && dly <= 25)}, 32'd1);
        chk("mid_pres_len", len, 32'd160);
        chk("mid_irq", irq_cnt - irq0, 32'd1);
        bus_rd(A_CTRL, rd);
        chk("mid_ctrl", rd, 32'h7000_0049);
        host_byte(8'hC3, rb);
        bus_rd(A_CTRL, rd);
        chk("ovr_ctrl", rd, 32'h7800_0049);
        bus_rd(A_DATA, rd);
        chk("ovr_C3", rd, 32'h0000_00C3);
        bus_wr(A_CTRL, 32'h0800_0049);
        bus_rd(A_CTRL, rd);
        chk("ovr_clr", rd, 32'h3000_0049);

        // Disable while the device is pulling the line low
        bus_wr(A_DATA, 32'h0000_0000);
        host_drv = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("dis_drv_low", {31'd0, onewire_o}, 32'd0);
        bus_wr(A_CTRL, 32'h0000_0048);
        chk("dis_release", {31'd0, onewire_o}, 32'd1);
        host_drv = 1'b1;
        repeat (5) @(negedge clk_i);
        bus_rd(A_CTRL, rd);
        chk("dis_ctrl", rd, 32'h2000_0048);
        chk("dis_clkgen", {31'd0, clkgen_en_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cellrv32_onewire_device.md
# cellrv32_onewire_device

1-Wire bus device (slave) controller: the responder counterpart to the CELLRV32 1-Wire host controller. It sits on the CPU IO bus and attaches to a shared 1-Wire line through an external open-drain driver. It detects host reset pulses and answers with a presence pulse. In each host time slot it receives one bit and, read-while-write, drives one bit out, LSB first. Byte completion and bus reset raise a one-cycle interrupt.

## Interface
- BASE_ADDR, 32'hFFFF_FE00: IO base. CTRL at +0, DATA at +4; decode uses addr_i[31:3].
- T_SAMPLE, 4: ticks after the falling edge at which a slot bit is sampled.
- T_DRIVE0, 6: ticks after the falling edge at which a driven 0 is released.
- T_RESET_MIN, 32: minimum low time, in ticks, classified as a bus reset.
- T_PDH, 2: ticks from line release to the start of the presence pulse.
- T_PDL, 16: presence pulse length in ticks.
- clk_i  in  1  global clock
- rstn_i  in  1  reset, asynchronous, active-low
- addr_i  in  32  access address
- rden_i  in  1  read enable
- wren_i  in  1  write enable
- data_i  in  32  write data
- data_o  out  32  read data; 0 when not reading
- ack_o  out  1  transfer acknowledge
- clkgen_en_o  out  1  enables the SoC clock generator; equals CTRL.en
- clkgen_i  in  8  SoC clock-enable taps; only [3:0] are used
- onewire_i  in  1  line state
- onewire_o  out  1  line pull-down; 0 pulls low, 1 releases
- irq_o  out  1  one-cycle event pulse

## Operation
- **CTRL register**
  - Bit 0: en.
  - Bits 2:1: prsc, selects clkgen_i[prsc].
  - Bits 10:3: clk_div.
  - Bit 27: overrun, write-1-to-clear.
  - Bit 28: reset_seen, write-1-to-clear.
  - Bit 29: sense, the synchronized line state (read-only).
  - Bit 30: rx_ready (read-only).
  - Bit 31: busy, meaning state is not IDLE or OFFLINE (read-only).
- **DATA register**
  - Write: loads tx_buf[7:0] and sets tx_valid.
  - Read: returns rx_byte and clears rx_ready.
- **Tick generation**
  - Divides the selected clkgen tap by clk_div+1.
  - Produces a one-cycle tick every t_base.
  - Counter is held at 0 while en=0.
- **Input path:** 2-FF synchronizer on onewire_i gives line_s. A falling edge is line_s 1→0.
- **FSM states:** OFFLINE, IDLE, SLOT, WAIT_HIGH, RST_LOW, PDH, PDL. en=0 forces OFFLINE from any state.
- **OFFLINE**
  - Clears rx_ready, overrun, reset_seen, bit_cnt, tx_valid.
  - Holds onewire_o=1.
  - Moves to IDLE when en=1.
- **IDLE**
  - On falling edge: tick_cnt←0, go to SLOT.
  - If bit_cnt=0, load tx_sreg←(tx_valid ? tx_buf : 8'hFF).
  - If the current tx bit is 0, drive onewire_o=0 from the next cycle.
- **SLOT**
  - tick_cnt increments on each tick, 7 bits, saturating at 127.
  - At the first tick where tick_cnt reaches T_SAMPLE: sample line_s into rx_sreg[7] via right shift, shift tx_sreg right, bit_cnt++.
  - The sample is the wired-AND line value, so the device's own 0 reads back as 0.
  - At tick_cnt=T_DRIVE0: release the line, go to WAIT_HIGH.
- **WAIT_HIGH**
  - Keeps counting.
  - line_s=1 goes to IDLE.
  - tick_cnt=T_RESET_MIN while still low goes to RST_LOW.
- **Byte complete** (bit_cnt wraps 7→0 at a sample)
  - rx_byte←rx_sreg; set overrun if rx_ready was already 1; rx_ready←1.
  - Clear tx_valid; pulse irq_o.
- **RST_LOW**
  - Entered from WAIT_HIGH, or from SLOT if tick_cnt reaches T_RESET_MIN first.
  - On entry: bit_cnt←0, partial byte discarded, reset_seen←1, irq_o pulse. tx_valid is preserved.
  - On line_s=1: tick_cnt←0, go to PDH.
- **PDH:** after T_PDH ticks, drive low and go to PDL.
- **PDL:** after T_PDL ticks, release and go to IDLE. Falling edges inside PDH/PDL are ignored.

## Timing
- **Reset values:** data_o=0, ack_o=0, onewire_o=1, irq_o=0, clkgen_en_o=0, all CTRL fields 0, FSM OFFLINE.
- **Bus access:** ack_o is asserted exactly 1 cycle after rden or wren when the address decodes. Read data is valid with ack_o.
- **Drive latency:**
  - onewire_o goes low 3 cycles after the onewire_i falling edge: 2 synchronizer cycles plus 1 registered-output cycle.
  - Release is registered, 1 cycle after the decision.
- **irq_o:** high for exactly one clk_i cycle per event.
- **Simultaneous byte-complete and DATA read in the same cycle:** byte-complete wins. rx_ready stays 1 and the new byte is held.
- **DATA write while bit_cnt≠0:** updates tx_buf only; it takes effect at the next byte start.
- **CTRL write:** W1C bits whose event sets them in the same cycle stay set.

## Configuration
- Macro `CELLRV32_ONEWIRE_DEV_GLITCH_FILTER_EN`.
- **Defined:** line_s changes only after the synchronized input is stable for 3 consecutive clk_i cycles. This adds 2 cycles to edge-detect latency, making drive latency 5 cycles, and suppresses pulses shorter than 3 cycles.
- **Undefined:** plain 2-FF synchronizer, no filter.

## Test plan
- **Reset and presence:** en=1, prsc=0, clk_div=9 (t_base=10 cycles). Host holds low 480 cycles (48 ticks), then releases. Required:
  - reset_seen=1 and one irq_o pulse.
  - onewire_o low starting about T_PDH ticks (≈20 cycles) after release, for 160 cycles.
- **Receive byte 0xA5:** host issues 8 slots (write-1: low 10 cycles; write-0: low 70 cycles; period 90). Required: rx_byte=0xA5, rx_ready=1, exactly one irq_o at the 8th sample.
- **Transmit byte 0x3C:** write DATA=0x3C. Host issues 8 write-1 slots sampling at tick 2. Required: host reads 0x3C; device rx_byte=0x3C (wired-AND); tx_valid cleared.
- **Reset mid-byte:** after 3 slots, a 48-tick low. Required: bit_cnt=0, rx_ready unchanged, reset_seen=1, presence pulse generated. The next 8 slots yield a full new byte.
- **Overrun:** receive two bytes without reading DATA. Required: overrun=1, rx_byte=second byte. Writing CTRL with bit 27=1 clears it.
- **Disable mid-slot:** clear en while onewire_o=0. Required: onewire_o=1 next cycle, state OFFLINE, CTRL bits 27–31 read 0 except sense.
